id_ex_stage: RTL and testbench

Decode-to-execute stage that produces the execute-stage ALU operand/opcode interface.
- Decodes the RV32I instruction held in ID and generates immediates.
- Selects ALU operands and alu_sel.
- Registers everything into the ID/EX pipeline register, with stall and flush control.
- Its outputs drive the execute-stage ALU (oprand_a, oprand_b, alu_sel) and the downstream EX/MEM control.

---
 rtl/id_ex_stage_pkg.sv | 69 ++++++
 rtl/id_ex_stage_imm_gen.sv | 24 ++
 rtl/id_ex_stage.sv | 184 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared encodings and the ID/EX bundle for the decode-to-execute stage.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] oprand_a;
        logic [31:0] oprand_b;
        logic [3:0]  alu_sel;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic        reg_wen;
        logic        mem_ren;
        logic        mem_wen;
        logic [2:0]  funct3;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        illegal;
    } id_ex_t;

    function automatic logic [3:0] op_alu(input logic [2:0] f3, input logic alt);
        logic [3:0] sel;
        unique case (f3)
            3'b000:  sel = alt ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// RV32I immediate generator; the format is chosen by the decoder.
module imm_gen
    import id_ex_stage_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        unique case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode, operand select and the ID/EX pipeline register.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_oprand_a,
    output logic [XLEN-1:0] ex_oprand_b,
    output logic [3:0]      ex_alu_sel,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_reg_wen,
    output logic            ex_mem_ren,
    output logic            ex_mem_wen,
    output logic [2:0]      ex_funct3,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_jalr,
    output logic            ex_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  funct7;
    logic        is_shift;
    imm_fmt_e    fmt;
    logic [31:0] imm;
    id_ex_t      dec;
    id_ex_t      ex_d;
    id_ex_t      ex_q;

    assign opcode   = id_instr[6:0];
    assign f3       = id_instr[14:12];
    assign funct7   = id_instr[31:25];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    always_comb begin
        fmt = IMM_NONE;
        unique case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
            OPC_STORE:                      fmt = IMM_S;
            OPC_BRANCH:                     fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
            OPC_JAL:                        fmt = IMM_J;
            default:                        fmt = IMM_NONE;
        endcase
    end

    imm_gen u_imm_gen (
        .instr (id_instr[31:7]),
        .fmt   (fmt),
        .imm   (imm)
    );

    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.pc       = id_pc;
        dec.rd_addr  = id_instr[11:7];
        dec.funct3   = f3;
        dec.rs2_data = id_rs2_data;
        dec.imm      = imm;
        dec.alu_sel  = ALU_ADD;
        unique case (opcode)
            OPC_OP: begin
                dec.oprand_a = id_rs1_data;
                dec.oprand_b = id_rs2_data;
                dec.alu_sel  = op_alu(f3, id_instr[30]);
                dec.reg_wen  = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.oprand_a = id_rs1_data;
                dec.oprand_b = imm;
                dec.alu_sel  = op_alu(f3, (f3 == 3'b101) && id_instr[30]);
                dec.reg_wen  = 1'b1;
                // shifts take only the shamt field; funct7 must be a legal pattern
                if (is_shift) begin
                    dec.oprand_b = {27'b0, id_instr[24:20]};
                    dec.illegal  = !((funct7 == 7'b0000000) ||
                                     ((f3 == 3'b101) && (funct7 == 7'b0100000)));
                end
            end
            OPC_LOAD: begin
                dec.oprand_a = id_rs1_data;
                dec.oprand_b = imm;
                dec.mem_ren  = 1'b1;
                dec.reg_wen  = 1'b1;
            end
            OPC_STORE: begin
                dec.oprand_a = id_rs1_data;
                dec.oprand_b = imm;
                dec.mem_wen  = 1'b1;
            end
            OPC_LUI: begin
                dec.alu_sel  = ALU_LUI;
                dec.oprand_b = imm;
                dec.reg_wen  = 1'b1;
            end
            OPC_AUIPC: begin
                dec.oprand_a = id_pc;
                dec.oprand_b = imm;
                dec.reg_wen  = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec.oprand_a = id_pc;
                dec.oprand_b = 32'd4;
                dec.jump     = 1'b1;
                dec.jalr     = (opcode == OPC_JALR);
                dec.reg_wen  = 1'b1;
            end
            OPC_BRANCH: begin
                dec.alu_sel  = ALU_SUB;
                dec.oprand_a = id_rs1_data;
                dec.oprand_b = id_rs2_data;
                dec.branch   = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.oprand_a = '0;
            dec.oprand_b = '0;
            dec.imm      = '0;
            dec.alu_sel  = ALU_ADD;
            dec.reg_wen  = 1'b0;
            dec.mem_ren  = 1'b0;
            dec.mem_wen  = 1'b0;
            dec.branch   = 1'b0;
            dec.jump     = 1'b0;
            dec.jalr     = 1'b0;
        end
        if (dec.rd_addr == 5'd0) begin
            dec.reg_wen = 1'b0;
        end
    end

    always_comb begin
        ex_d = dec;
        if (flush || (!stall && !id_valid)) begin
            ex_d = '0;
        end else if (stall) begin
            ex_d = ex_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            ex_q.pc <= RESET_PC;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_oprand_a = ex_q.oprand_a;
    assign ex_oprand_b = ex_q.oprand_b;
    assign ex_alu_sel  = ex_q.alu_sel;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm      = ex_q.imm;
    assign ex_pc       = ex_q.pc;
    assign ex_rd_addr  = ex_q.rd_addr;
    assign ex_reg_wen  = ex_q.reg_wen;
    assign ex_mem_ren  = ex_q.mem_ren;
    assign ex_mem_wen  = ex_q.mem_wen;
    assign ex_funct3   = ex_q.funct3;
    assign ex_branch   = ex_q.branch;
    assign ex_jump     = ex_q.jump;
    assign ex_jalr     = ex_q.jalr;
    assign ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and random checks of id_ex_stage against a behavioural model.
module tb_id_ex_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [31:0] id_instr, id_pc, id_rs1_data, id_rs2_data;
    logic        ex_valid;
    logic [31:0] ex_oprand_a, ex_oprand_b, ex_rs2_data, ex_imm, ex_pc;
    logic [3:0]  ex_alu_sel;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_wen, ex_mem_ren, ex_mem_wen;
    logic [2:0]  ex_funct3;
    logic        ex_branch, ex_jump, ex_jalr, ex_illegal;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  alu;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic        ren;
        logic        mwen;
        logic [2:0]  f3;
        logic        br;
        logic        jmp;
        logic        jalr;
        logic        ill;
    } exp_t;

    exp_t m;
    int   alu_tab [8] = '{0, 7, 2, 3, 4, 8, 5, 6};

    always #5 clk = ~clk;

    id_ex_stage #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_rs1_data (id_rs1_data),
        .id_rs2_data (id_rs2_data),
        .ex_valid    (ex_valid),
        .ex_oprand_a (ex_oprand_a),
        .ex_oprand_b (ex_oprand_b),
        .ex_alu_sel  (ex_alu_sel),
        .ex_rs2_data (ex_rs2_data),
        .ex_imm      (ex_imm),
        .ex_pc       (ex_pc),
        .ex_rd_addr  (ex_rd_addr),
        .ex_reg_wen  (ex_reg_wen),
        .ex_mem_ren  (ex_mem_ren),
        .ex_mem_wen  (ex_mem_wen),
        .ex_funct3   (ex_funct3),
        .ex_branch   (ex_branch),
        .ex_jump     (ex_jump),
        .ex_jalr     (ex_jalr),
        .ex_illegal  (ex_illegal)
    );

    function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        int si, ss, sb, sj;
        logic [31:0] iu;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        si = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
        ss = int'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0);
        sb = int'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2 - (ins[31] ? 8192 : 0);
        sj = int'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2 - (ins[31] ? 2097152 : 0);
        iu = 32'(ins[31:12]) * 32'd4096;
        e = '0;
        e.valid = 1'b1;
        e.pc = pc;
        e.rd = ins[11:7];
        e.f3 = f3;
        e.rs2 = r2;
        case (ins[6:0])
            7'h33: begin
                e.a = r1; e.b = r2; e.wen = 1'b1;
                e.alu = 4'(alu_tab[f3]);
                if (f3 == 3'd0 && ins[30]) e.alu = 4'd1;
                if (f3 == 3'd5 && ins[30]) e.alu = 4'd9;
            end
            7'h13: begin
                e.a = r1; e.b = 32'(si); e.imm = 32'(si); e.wen = 1'b1;
                e.alu = 4'(alu_tab[f3]);
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.b = 32'(ins[24:20]);
                    if (f3 == 3'd5 && ins[30]) e.alu = 4'd9;
                    if (!(f7 == 7'd0 || (f3 == 3'd5 && f7 == 7'h20))) e.ill = 1'b1;
                end
            end
            7'h03: begin
                e.a = r1; e.b = 32'(si); e.imm = 32'(si); e.ren = 1'b1; e.wen = 1'b1;
            end
            7'h23: begin
                e.a = r1; e.b = 32'(ss); e.imm = 32'(ss); e.mwen = 1'b1;
            end
            7'h37: begin
                e.alu = 4'd10; e.b = iu; e.imm = iu; e.wen = 1'b1;
            end
            7'h17: begin
                e.a = pc; e.b = iu; e.imm = iu; e.wen = 1'b1;
            end
            7'h6F: begin
                e.a = pc; e.b = 32'd4; e.imm = 32'(sj); e.jmp = 1'b1; e.wen = 1'b1;
            end
            7'h67: begin
                e.a = pc; e.b = 32'd4; e.imm = 32'(si); e.jmp = 1'b1; e.jalr = 1'b1;
                e.wen = 1'b1;
            end
            7'h63: begin
                e.alu = 4'd1; e.a = r1; e.b = r2; e.imm = 32'(sb); e.br = 1'b1;
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.a = '0; e.b = '0; e.imm = '0; e.alu = 4'd0;
            e.wen = 0; e.ren = 0; e.mwen = 0; e.br = 0; e.jmp = 0; e.jalr = 0;
        end
        if (e.rd == 5'd0) e.wen = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid", 32'(ex_valid), 32'(m.valid));
        chk("oprand_a", ex_oprand_a, m.a);
        chk("oprand_b", ex_oprand_b, m.b);
        chk("alu_sel", 32'(ex_alu_sel), 32'(m.alu));
        chk("rs2_data", ex_rs2_data, m.rs2);
        chk("imm", ex_imm, m.imm);
        chk("pc", ex_pc, m.pc);
        chk("rd_addr", 32'(ex_rd_addr), 32'(m.rd));
        chk("reg_wen", 32'(ex_reg_wen), 32'(m.wen));
        chk("mem_ren", 32'(ex_mem_ren), 32'(m.ren));
        chk("mem_wen", 32'(ex_mem_wen), 32'(m.mwen));
        chk("funct3", 32'(ex_funct3), 32'(m.f3));
        chk("branch", 32'(ex_branch), 32'(m.br));
        chk("jump", 32'(ex_jump), 32'(m.jmp));
        chk("jalr", 32'(ex_jalr), 32'(m.jalr));
        chk("illegal", 32'(ex_illegal), 32'(m.ill));
    endtask

    task automatic step(input logic r, input logic fl, input logic st, input logic v,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t nxt;
        rst = r; flush = fl; stall = st; id_valid = v;
        id_instr = ins; id_pc = pc; id_rs1_data = r1; id_rs2_data = r2;
        if (r) begin
            nxt = '0;
            nxt.pc = RST_PC;
        end else if (fl || (!st && !v)) begin
            nxt = '0;
        end else if (st) begin
            nxt = m;
        end else begin
            nxt = ref_model(ins, pc, r1, r2);
        end
        @(posedge clk);
        #1;
        m = nxt;
        check_all();
    endtask

    initial begin
        logic [31:0] ins, tmp;
        logic [6:0]  opc [10];
        opc = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h7F};
        m = '0;

        step(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(1, 0, 0, 1, 32'h402081B3, 32'h10, 32'd10, 32'd3);
        chk("rst_pc", ex_pc, 32'h0000_0200);
        chk("rst_valid", 32'(ex_valid), 32'd0);

        step(0, 0, 0, 1, 32'h402081B3, 32'h10, 32'd10, 32'd3);
        chk("sub_alu", 32'(ex_alu_sel), 32'd1);
        chk("sub_a", ex_oprand_a, 32'd10);
        chk("sub_b", ex_oprand_b, 32'd3);
        chk("sub_rd", 32'(ex_rd_addr), 32'd3);
        chk("sub_wen", 32'(ex_reg_wen), 32'd1);

        step(0, 0, 0, 1, 32'hFFF00293, 32'h14, 32'h55, 32'h66);
        chk("addi_b", ex_oprand_b, 32'hFFFF_FFFF);
        step(0, 0, 0, 1, 32'h4042D293, 32'h18, 32'h8000_0000, 32'h0);
        chk("srai_alu", 32'(ex_alu_sel), 32'd9);
        chk("srai_b", ex_oprand_b, 32'd4);

        step(0, 0, 0, 1, 32'h123453B7, 32'h1C, 32'h1, 32'h2);
        chk("lui_b", ex_oprand_b, 32'h1234_5000);
        chk("lui_alu", 32'(ex_alu_sel), 32'd10);
        step(0, 0, 0, 1, 32'h00001297, 32'h100, 32'h1, 32'h2);
        chk("auipc_a", ex_oprand_a, 32'h100);
        chk("auipc_b", ex_oprand_b, 32'h1000);

        step(0, 0, 0, 1, 32'h008000EF, 32'h40, 32'h1, 32'h2);
        chk("jal_imm", ex_imm, 32'd8);
        chk("jal_b", ex_oprand_b, 32'd4);
        step(0, 0, 0, 1, 32'h00208863, 32'h44, 32'h7, 32'h7);
        chk("beq_branch", 32'(ex_branch), 32'd1);
        chk("beq_imm", ex_imm, 32'd16);

        step(0, 0, 0, 1, 32'h402081B3, 32'h48, 32'd20, 32'd5);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, i[0], 32'h123453B7 + 32'(i), 32'h60 + 32'(i), 32'(i), 32'(i));
            chk("stall_pc", ex_pc, 32'h48);
        end
        step(0, 1, 1, 1, 32'h402081B3, 32'h70, 32'd1, 32'd1);
        chk("flush_stall_valid", 32'(ex_valid), 32'd0);

        step(0, 0, 0, 1, 32'h0000007F, 32'h74, 32'h1, 32'h2);
        chk("illegal", 32'(ex_illegal), 32'd1);
        step(0, 0, 0, 1, 32'h00208033, 32'h78, 32'h1, 32'h2);
        chk("x0_wen", 32'(ex_reg_wen), 32'd0);
        step(0, 0, 0, 0, 32'h00208033, 32'h7C, 32'h1, 32'h2);
        step(0, 0, 0, 1, 32'h00A00093, 32'h80, 32'h1, 32'h2);
        step(1, 0, 0, 1, 32'h00A00093, 32'h84, 32'h1, 32'h2);
        chk("mid_rst_pc", ex_pc, 32'h0000_0200);

        for (int i = 0; i < 400; i++) begin
            tmp = $urandom();
            ins = {tmp[31:7], opc[$urandom_range(0, 9)]};
            if (ins[6:0] == 7'h13 && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5)) begin
                case ($urandom_range(0, 2))
                    0: ins[31:25] = 7'h00;
                    1: ins[31:25] = 7'h20;
                    default: ;
                endcase
            end
            step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 85,
                 ins, $urandom(), $urandom(), $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
